// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier, one adder pass per cycle,
// 2*WIDTH-bit product after WIDTH iterations.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d, shifted;
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    // the adder carry-out lands in the acc_hi MSB after the shift
    shifted = acc_lo_q[0] ? {sum, acc_lo_q[WIDTH-1:1]} : {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
    state_d = state_q;
    mcand_d = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = A;
        acc_hi_d = '0;
        acc_lo_d = B;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = shifted;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q <= cnt_d;
      product_q <= product_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scenario tasks drive the multiplier; a done-triggered scoreboard checks products.
module tb_shift_add_multiplier;
  localparam int W = 4;
  logic clk = 0, rst = 0, start = 0;
  logic [W-1:0] A = '0, B = '0;
  logic [2*W-1:0] product;
  logic busy, done;
  int errors = 0, checks = 0, done_cnt = 0;
  logic prev_done = 0;
  logic [2*W-1:0] last_prod = '0;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // scoreboard: each done pulse pops one expected product
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: product=%h with no pending operation", product);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL sb_product: got %h expected %h", product, e);
        end
      end
      checks++;
      if (busy !== 1'b0 || prev_done === 1'b1) begin
        errors++;
        $display("FAIL sb_done_shape: busy=%b prev_done=%b expected 0 0", busy, prev_done);
      end
    end
    prev_done <= done;
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1; start = 1; A = 15; B = 15;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: product=%h busy=%b done=%b expected 00 0 0", product, busy, done);
      end
    end
    rst = 0; start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    exp_q.push_back(8'hE1);
    A = 15; B = 15; start = 1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== last_prod) begin
        errors++;
        $display("FAIL basic_run[%0d]: busy=%b done=%b product=%h expected 1 0 %h", i, busy, done, product, last_prod);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b expected 1 0", done, busy);
    end
    last_prod = 8'hE1;
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 8'hE1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: product=%h done=%b busy=%b expected e1 0 0", product, done, busy);
    end
  endtask

  task automatic test_mixed();
    logic [W-1:0] ta[3] = '{4'd13, 4'd1, 4'd0};
    logic [W-1:0] tb[3] = '{4'd11, 4'd15, 4'd9};
    for (int t = 0; t < 3; t++) begin
      logic [2*W-1:0] e;
      int n;
      e = ta[t] * tb[t];
      exp_q.push_back(e);
      A = ta[t]; B = tb[t]; start = 1;
      n = 0;
      while (n < 20 && done !== 1'b1) begin
        @(negedge clk);
        start = 0;
        A = ~A; B = ~B;
        n++;
        if (busy === 1'b1 && product !== last_prod) begin
          errors++;
          $display("FAIL mixed_hold[%0d]: product=%h expected %h", t, product, last_prod);
        end
      end
      checks++;
      if (n != W + 1) begin
        errors++;
        $display("FAIL mixed_latency[%0d]: done after %0d cycles expected %0d", t, n, W + 1);
      end
      last_prod = e;
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    int d0;
    int n;
    d0 = done_cnt;
    exp_q.push_back(8'd42);
    A = 7; B = 6; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; A = 3; B = 3;
    @(negedge clk);
    start = 0;
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_timeout: done=%b expected 1", done);
    end
    start = 1; A = 3; B = 3;
    @(negedge clk);
    start = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd42) begin
        errors++;
        $display("FAIL ignored_idle: busy=%b done=%b product=%h expected 0 0 2a", busy, done, product);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignored_pulses: %0d done pulses expected 1", done_cnt - d0);
    end
    last_prod = 8'd42;
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    exp_q.push_back(8'h51);
    A = 9; B = 9; start = 1;
    n1 = 0;
    while (n1 < 20 && done !== 1'b1) begin
      @(negedge clk);
      n1++;
    end
    checks++;
    if (n1 != W + 1) begin
      errors++;
      $display("FAIL b2b_first_latency: %0d cycles expected %0d", n1, W + 1);
    end
    A = 5; B = 4;
    exp_q.push_back(8'h14);
    n2 = 0;
    do begin
      @(negedge clk);
      n2++;
      if (n2 == 2) start = 0;
    end while (n2 < 20 && done !== 1'b1);
    checks++;
    if (n2 != W + 2) begin
      errors++;
      $display("FAIL b2b_spacing: done pulses %0d cycles apart expected %0d", n2, W + 2);
    end
    start = 0;
    last_prod = 8'h14;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    int n;
    A = 15; B = 15; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    d0 = done_cnt;
    checks++;
    if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: product=%h busy=%b done=%b expected 00 0 0", product, busy, done);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done: pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    exp_q.push_back(8'h06);
    A = 2; B = 3; start = 1;
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      @(negedge clk);
      start = 0;
      n++;
    end
    checks++;
    if (n != W + 1 || product !== 8'h06) begin
      errors++;
      $display("FAIL mid_reset_restart: latency=%0d product=%h expected %0d 06", n, product, W + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d products still pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned multiplier built around the team's WIDTH-bit ripple-carry adder stage. It consumes the adder's sum and carry-out once per cycle, accumulates partial products and shifts them, and delivers a 2*WIDTH-bit product after WIDTH iterations. It sits directly downstream of the adder. It replaces a combinational array multiplier wherever area matters more than latency.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16; product width is 2*WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  request to multiply; accepted only in IDLE.
- A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge only.
- B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge only.
- product  output  2*WIDTH  registered result; holds the last completed product.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; marks the cycle in which a new product is first valid.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - mcand (WIDTH), captured copy of A.
  - acc_hi (WIDTH), upper accumulator.
  - acc_lo (WIDTH), initially B; shifts out multiplier bits.
  - cnt (clog2(WIDTH)+1 bits).
- IDLE, start=1: mcand<=A, acc_hi<=0, acc_lo<=B, cnt<=0, go to RUN. With start=0, stay in IDLE.
- RUN, each cycle, one iteration:
  - Adder inputs are acc_hi, mcand and carry-in 0, giving sum s and carry-out c.
  - If acc_lo[0]=1, next {c, s, acc_lo} is shifted right by 1 into {acc_hi, acc_lo}.
  - If acc_lo[0]=0, {0, acc_hi, acc_lo} is shifted right by 1 instead.
  - The carry-out is never dropped; it becomes acc_hi MSB after the shift.
  - cnt<=cnt+1.
- RUN, iteration with cnt=WIDTH-1 (the last one):
  - product is loaded with the post-shift {acc_hi, acc_lo}.
  - State moves to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored; it is not queued. A and B changing while busy has no effect.
- product changes only on the final RUN edge; it holds its value through IDLE and RUN of the next operation.
- All arithmetic is unsigned. No overflow is possible, since (2^WIDTH-1)^2 < 2^(2*WIDTH).
- rst=1 on any edge, including mid-RUN:
  - state<=IDLE; product, busy, done, acc, mcand and cnt all go to 0.
  - The aborted operation produces no done pulse.
  - rst has priority over start on the same edge.

## Timing
- Reset values: product=0, busy=0, done=0.
- Let start be accepted at edge k.
  - busy is high for cycles k..k+WIDTH, i.e. after edges k through k+WIDTH-1; that is WIDTH cycles.
  - product is updated at edge k+WIDTH.
  - done=1 for the single cycle after edge k+WIDTH (state DONE).
  - State returns to IDLE at edge k+WIDTH+1.
- Latency from the accepting edge to valid product is WIDTH edges.
- Earliest next accept is edge k+WIDTH+2. Throughput is one product per WIDTH+2 cycles with start held high.
- busy and done are never high together. done is never high for 2 consecutive cycles.
- Critical path is one WIDTH-bit ripple add plus a mux into acc_hi; there is no combinational path from inputs to outputs.

## Test plan
- Reset, WIDTH=4: assert rst for 2 cycles, with start=1 and A=B=15 -> product=0x00, busy=0, done=0, and no operation starts while rst is high.
- Basic, carry-out exercised: A=15, B=15, start pulsed at edge k -> busy=1 for 4 cycles, done=1 in the cycle after edge k+4, product=0xE1 (225), held stable until the next accept.
- Mixed bits: A=13, B=11 -> product=0x8F (143). A=1, B=15 -> 0x0F. A=0, B=9 -> 0x00, with latency still 4 edges and done still pulsing.
- Ignored start: run A=7, B=6; pulse start with A=3, B=3 in a RUN cycle and again in the DONE cycle -> product=0x2A (42), exactly one done pulse, state IDLE afterwards.
- Back-to-back: hold start=1 with A=9, B=9, then change to A=5, B=4 after the first done -> products 0x51 then 0x14; accepts are 6 edges apart.
- Reset mid-operation: A=15, B=15, assert rst at the 2nd RUN edge -> product=0, busy=0, no done. A new start with A=2, B=3 then gives product=0x06 with normal timing.
